// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage; runs LW/SW over a req/valid
// handshake with timeout, stalls upstream while busy, drives MEM/WB outputs.
module mem_stage #(
    parameter logic [3:0] LW_OPC  = 4'b1000,
    parameter logic [3:0] SW_OPC  = 4'b1001,
    parameter int         TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_result,
    input  logic [3:0]  ex_dst,
    input  logic        ex_wen,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [3:0]  wb_dst,
    output logic [15:0] wb_data,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [3:0]  cap_dst, cap_dst_nxt;
    logic        req_nxt, we_nxt, err_nxt;
    logic [15:0] addr_nxt, wdata_nxt;
    logic        wb_valid_nxt, wb_wen_nxt;
    logic [3:0]  wb_dst_nxt;
    logic [15:0] wb_data_nxt;
    logic        is_mem, timeout_hit;

    assign is_mem      = ex_valid & ((ex_opcode == LW_OPC) | (ex_opcode == SW_OPC));
    assign timeout_hit = (state == BUSY) & ~mem_valid & (cnt == 8'(TIMEOUT - 1));
    assign stall       = ((state == IDLE) & is_mem) | ((state == BUSY) & ~mem_valid & ~timeout_hit);

    // Next-state, memory-port and MEM/WB values; everything holds by default.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap_dst_nxt  = cap_dst;
        req_nxt      = mem_req;
        we_nxt       = mem_we;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        err_nxt      = err;
        wb_valid_nxt = 1'b0;
        wb_wen_nxt   = 1'b0;
        wb_dst_nxt   = wb_dst;
        wb_data_nxt  = wb_data;
        if (state == IDLE) begin
            if (is_mem) begin
                state_nxt   = BUSY;
                cnt_nxt     = 8'd0;
                cap_dst_nxt = ex_dst;
                req_nxt     = 1'b1;
                we_nxt      = (ex_opcode == SW_OPC);
                addr_nxt    = ex_addr & 16'hFFFE;
                wdata_nxt   = ex_result;
            end else if (ex_valid) begin
                wb_valid_nxt = 1'b1;
                wb_wen_nxt   = ex_wen;
                wb_dst_nxt   = ex_dst;
                wb_data_nxt  = ex_result;
            end
        end else if (mem_valid) begin
            state_nxt    = IDLE;
            cnt_nxt      = 8'd0;
            req_nxt      = 1'b0;
            wb_valid_nxt = 1'b1;
            wb_wen_nxt   = ~mem_we;
            wb_dst_nxt   = cap_dst;
            wb_data_nxt  = mem_we ? mem_wdata : mem_rdata;
        end else if (timeout_hit) begin
            // Aborted access still retires so the pipeline keeps its order,
            // but it never writes the register file.
            state_nxt    = IDLE;
            cnt_nxt      = 8'd0;
            req_nxt      = 1'b0;
            err_nxt      = 1'b1;
            wb_valid_nxt = 1'b1;
            wb_dst_nxt   = cap_dst;
        end else begin
            cnt_nxt = cnt + 8'd1;
        end
    end

    // State and output registers; reset drops mem_req without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cap_dst   <= 4'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            err       <= 1'b0;
            wb_valid  <= 1'b0;
            wb_wen    <= 1'b0;
            wb_dst    <= 4'h0;
            wb_data   <= 16'h0000;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cap_dst   <= cap_dst_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            err       <= err_nxt;
            wb_valid  <= wb_valid_nxt;
            wb_wen    <= wb_wen_nxt;
            wb_dst    <= wb_dst_nxt;
            wb_data   <= wb_data_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a retire scoreboard.
module tb_mem_stage;

    localparam logic [3:0] LW  = 4'b1000;
    localparam logic [3:0] SW  = 4'b1001;
    localparam logic [3:0] ADD = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_wen;
    logic [3:0]  ex_opcode, ex_dst;
    logic [15:0] ex_addr, ex_result;
    logic        mem_req, mem_we, mem_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, wb_valid, wb_wen, err;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;

    typedef struct packed {
        logic        full;
        logic        wen;
        logic [3:0]  dst;
        logic [15:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    mem_stage #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_addr(ex_addr),
        .ex_result(ex_result), .ex_dst(ex_dst), .ex_wen(ex_wen),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .stall(stall), .wb_valid(wb_valid), .wb_wen(wb_wen),
        .wb_dst(wb_dst), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input logic full, input logic wen, input logic [3:0] dst, input logic [15:0] data);
        wb_t e;
        e.full = full;
        e.wen  = wen;
        e.dst  = dst;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Cross one rising edge, then score any retire against the queue head.
    task automatic tick();
        wb_t e;
        @(posedge clk);
        #1;
        if (wb_valid === 1'b1) begin
            chk("retire_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_wen", wb_wen, e.wen);
                if (e.full) begin
                    chk("wb_dst", wb_dst, e.dst);
                    chk("wb_data", wb_data, e.data);
                end
            end
        end
    endtask

    task automatic present(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] res,
                           input logic [3:0] dst, input logic wen);
        ex_valid  = 1'b1;
        ex_opcode = op;
        ex_addr   = addr;
        ex_result = res;
        ex_dst    = dst;
        ex_wen    = wen;
    endtask

    initial begin
        rst_n = 1'b1;
        ex_valid = 1'b0; ex_opcode = 4'h0; ex_addr = 16'h0; ex_result = 16'h0;
        ex_dst = 4'h0; ex_wen = 1'b0; mem_valid = 1'b0; mem_rdata = 16'h0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_wen", wb_wen, 0);
        chk("rst wb_dst", wb_dst, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst err", err, 0);
        chk("rst stall", stall, 0);
        @(negedge clk) rst_n = 1'b1;

        // ADD passthrough
        present(ADD, 16'h0000, 16'h1234, 4'd3, 1'b1);
        expect_wb(1, 1, 4'd3, 16'h1234);
        #1 chk("add stall", stall, 0);
        tick();
        chk("add wb_valid", wb_valid, 1);
        ex_valid = 1'b0;
        #1 chk("idle stall", stall, 0);
        tick();
        chk("bubble wb_valid", wb_valid, 0);
        chk("bubble wb_data hold", wb_data, 16'h1234);

        // LW, zero wait
        present(LW, 16'h0041, 16'h0000, 4'd5, 1'b0);
        expect_wb(1, 1, 4'd5, 16'hBEEF);
        #1 chk("lw0 stall c0", stall, 1);
        tick();
        chk("lw0 mem_req", mem_req, 1);
        chk("lw0 mem_addr", mem_addr, 16'h0040);
        chk("lw0 mem_we", mem_we, 0);
        mem_valid = 1'b1; mem_rdata = 16'hBEEF;
        #1 chk("lw0 stall c1", stall, 0);
        tick();
        chk("lw0 wb_valid", wb_valid, 1);
        chk("lw0 req drop", mem_req, 0);
        mem_valid = 1'b0; ex_valid = 1'b0;

        // mem_valid while IDLE must be ignored
        mem_valid = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        chk("idle mem_valid ignored", wb_valid, 0);
        mem_valid = 1'b0;

        // SW with 3 wait cycles
        present(SW, 16'h0100, 16'hA5A5, 4'd7, 1'b1);
        expect_wb(1, 0, 4'd7, 16'hA5A5);
        #1 chk("sw stall c0", stall, 1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            chk("sw mem_req", mem_req, 1);
            chk("sw mem_we", mem_we, 1);
            chk("sw mem_wdata", mem_wdata, 16'hA5A5);
            chk("sw mem_addr", mem_addr, 16'h0100);
            chk("sw stall wait", stall, 1);
            tick();
        end
        mem_valid = 1'b1;
        chk("sw mem_req c4", mem_req, 1);
        chk("sw mem_we c4", mem_we, 1);
        #1 chk("sw stall c4", stall, 0);
        tick();
        chk("sw wb_valid", wb_valid, 1);
        mem_valid = 1'b0; ex_valid = 1'b0;

        // LW followed by ADD held behind it
        present(LW, 16'h0200, 16'h0000, 4'd2, 1'b0);
        expect_wb(1, 1, 4'd2, 16'h1111);
        tick();
        #1 chk("lwadd stall c1", stall, 1);
        tick();
        mem_valid = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_valid = 1'b0;
        present(ADD, 16'h0000, 16'h4444, 4'd4, 1'b1);
        expect_wb(1, 1, 4'd4, 16'h4444);
        #1 chk("lwadd add stall", stall, 0);
        tick();
        chk("lwadd add retire", wb_valid, 1);
        ex_valid = 1'b0;
        tick();
        chk("lwadd no dup", wb_valid, 0);

        // Timeout with TIMEOUT=8
        present(LW, 16'h0300, 16'h0000, 4'd6, 1'b0);
        expect_wb(0, 0, 4'd6, 16'h0000);
        tick();
        for (int i = 1; i <= 7; i++) begin
            chk("to mem_req", mem_req, 1);
            #1 chk("to stall", stall, 1);
            tick();
        end
        chk("to mem_req c8", mem_req, 1);
        #1 chk("to stall c8", stall, 0);
        tick();
        chk("to req drop", mem_req, 0);
        chk("to err", err, 1);
        chk("to wb_valid", wb_valid, 1);
        present(ADD, 16'h0000, 16'h9999, 4'd9, 1'b1);
        expect_wb(1, 1, 4'd9, 16'h9999);
        tick();
        chk("to add retire", wb_valid, 1);
        chk("to err sticky", err, 1);
        ex_valid = 1'b0;
        tick();
        chk("to err sticky2", err, 1);

        // Reset mid-access
        present(LW, 16'h0400, 16'h0000, 4'd1, 1'b0);
        tick();
        tick();
        chk("rst2 busy req", mem_req, 1);
        #2 rst_n = 1'b0; ex_valid = 1'b0;
        #1;
        chk("rst2 mem_req", mem_req, 0);
        chk("rst2 wb_valid", wb_valid, 0);
        chk("rst2 stall", stall, 0);
        chk("rst2 err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        present(LW, 16'h0503, 16'h0000, 4'd8, 1'b0);
        expect_wb(1, 1, 4'd8, 16'hC0DE);
        tick();
        chk("rst2 new addr", mem_addr, 16'h0502);
        mem_valid = 1'b1; mem_rdata = 16'hC0DE;
        tick();
        chk("rst2 new retire", wb_valid, 1);
        mem_valid = 1'b0; ex_valid = 1'b0;
        tick();

        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
